// File: rtl/llfifo_scheduler_if.sv
// Upstream write port and downstream read port of the linked-list FIFO scheduler.
interface llfifo_scheduler_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ID_WIDTH = 1
);
    logic                in_valid;
    logic [ID_WIDTH-1:0] in_id;
    logic [WIDTH-1:0]    in_data;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [ID_WIDTH-1:0] out_id;

    modport master (
        output in_valid, in_id, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  in_valid, in_id, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/llfifo_scheduler.sv
// Push/pop sequencer for the shared-memory linked-list FIFO bank: steers tagged
// writes into the addressed FIFO, drains non-empty FIFOs round-robin into one
// registered output, and issues at most one one-hot bank op per cycle.
module llfifo_scheduler #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_FIFOS = 2,
    parameter int unsigned ID_WIDTH  = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    llfifo_scheduler_if.slave    bus,
    output logic                 id_err,
    output logic [NUM_FIFOS-1:0] ff_push,
    output logic [NUM_FIFOS-1:0] ff_pop,
    output logic [WIDTH-1:0]     ff_data_in,
    input  logic                 ff_full,
    input  logic [NUM_FIFOS-1:0] ff_empty,
    input  logic [WIDTH-1:0]     ff_data_out
);

    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_data_q;
    logic [ID_WIDTH-1:0]  out_id_q;
    logic [ID_WIDTH-1:0]  rr_ptr;
    logic                 pri;

    logic [NUM_FIFOS-1:0] ne_vec;
    logic [NUM_FIFOS-1:0] ne_shift;
    logic [ID_WIDTH-1:0]  pop_sel;
    logic                 pop_found;
    int unsigned          rr_idx;

    logic                 slot_free;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 do_push;
    logic                 do_pop;
    logic                 id_ok;

    assign ne_vec        = ~ff_empty;
    assign ff_data_in    = bus.in_data;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;

    // Round-robin pick: first non-empty FIFO after rr_ptr, wrapping.
    always_comb begin
        pop_sel   = '0;
        pop_found = 1'b0;
        rr_idx    = 0;
        ne_shift  = '0;
        for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
            rr_idx = 32'(rr_ptr) + k;
            if (rr_idx >= NUM_FIFOS) begin
                rr_idx = rr_idx - NUM_FIFOS;
            end
            ne_shift = ne_vec >> rr_idx;
            if (!pop_found && ne_shift[0]) begin
                pop_found = 1'b1;
                pop_sel   = ID_WIDTH'(rr_idx);
            end
        end
    end

    // Push/pop arbitration; pri breaks ties so sustained demand alternates.
    always_comb begin
        slot_free    = !out_valid_q || bus.out_ready;
        push_ok      = bus.in_valid && !ff_full && !rst;
        pop_ok       = slot_free && (|ne_vec) && !rst;
        do_push      = push_ok && (!pop_ok || pri);
        do_pop       = pop_ok && (!push_ok || !pri);
        id_ok        = 32'(bus.in_id) < NUM_FIFOS;
        bus.in_ready = do_push;
        ff_push      = '0;
        ff_pop       = '0;
        if (do_push && id_ok) begin
            ff_push = NUM_FIFOS'(1) << bus.in_id;
        end
        if (do_pop) begin
            ff_pop = NUM_FIFOS'(1) << pop_sel;
        end
    end

    // Output register, round-robin pointer, tie-break priority and id error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr      <= ID_WIDTH'(NUM_FIFOS - 1);
            pri         <= 1'b0;
            id_err      <= 1'b0;
        end else begin
            if (do_pop) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ff_data_out;
                out_id_q    <= pop_sel;
                rr_ptr      <= pop_sel;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (push_ok && pop_ok) begin
                pri <= ~pri;
            end
            id_err <= do_push && !id_ok;
        end
    end

endmodule

// File: tb/tb_llfifo_scheduler.sv
// Directed bench for llfifo_scheduler: a 2-FIFO instance backed by a small
// depth-4 bank model, and a 3-FIFO instance with hand-driven bank status.
module tb_llfifo_scheduler;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: NUM_FIFOS=2 with bank model
    llfifo_scheduler_if #(.WIDTH(8), .ID_WIDTH(1)) bus_a ();
    logic       id_err_a;
    logic [1:0] ff_push_a;
    logic [1:0] ff_pop_a;
    logic [7:0] ff_data_in_a;
    logic       ff_full_a;
    logic [1:0] ff_empty_a;
    logic [7:0] ff_data_out_a;

    llfifo_scheduler #(.WIDTH(8), .NUM_FIFOS(2)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_a),
        .id_err     (id_err_a),
        .ff_push    (ff_push_a),
        .ff_pop     (ff_pop_a),
        .ff_data_in (ff_data_in_a),
        .ff_full    (ff_full_a),
        .ff_empty   (ff_empty_a),
        .ff_data_out(ff_data_out_a)
    );

    // Instance B: NUM_FIFOS=3, bank status driven directly
    llfifo_scheduler_if #(.WIDTH(8), .ID_WIDTH(2)) bus_b ();
    logic       id_err_b;
    logic [2:0] ff_push_b;
    logic [2:0] ff_pop_b;
    logic [7:0] ff_data_in_b;
    logic       b_full;
    logic [2:0] b_empty;
    logic [7:0] b_data_out;

    llfifo_scheduler #(.WIDTH(8), .NUM_FIFOS(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_b),
        .id_err     (id_err_b),
        .ff_push    (ff_push_b),
        .ff_pop     (ff_pop_b),
        .ff_data_in (ff_data_in_b),
        .ff_full    (b_full),
        .ff_empty   (b_empty),
        .ff_data_out(b_data_out)
    );

    // Bank model: two FIFOs sharing four entries; preload sets FIFO0={1,2}, FIFO1={3,4}
    logic       preload;
    logic [7:0] bk_mem  [2][4];
    logic [1:0] bk_head [2];
    logic [2:0] bk_cnt  [2];

    assign ff_full_a  = (bk_cnt[0] + bk_cnt[1]) == 3'd4;
    assign ff_empty_a = {bk_cnt[1] == 3'd0, bk_cnt[0] == 3'd0};

    always_comb begin
        ff_data_out_a = 8'h00;
        if (ff_pop_a[0]) ff_data_out_a = bk_mem[0][bk_head[0]];
        else if (ff_pop_a[1]) ff_data_out_a = bk_mem[1][bk_head[1]];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                bk_head[1'(i)] <= 2'd0;
                bk_cnt[1'(i)]  <= 3'd0;
            end
        end else if (preload) begin
            bk_mem[0][0] <= 8'h01;
            bk_mem[0][1] <= 8'h02;
            bk_mem[1][0] <= 8'h03;
            bk_mem[1][1] <= 8'h04;
            for (int i = 0; i < 2; i++) begin
                bk_head[1'(i)] <= 2'd0;
                bk_cnt[1'(i)]  <= 3'd2;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ff_push_a[1'(i)]) begin
                    bk_mem[1'(i)][bk_head[1'(i)] + bk_cnt[1'(i)][1:0]] <= ff_data_in_a;
                    bk_cnt[1'(i)] <= bk_cnt[1'(i)] + 3'd1;
                end else if (ff_pop_a[1'(i)]) begin
                    bk_head[1'(i)] <= bk_head[1'(i)] + 2'd1;
                    bk_cnt[1'(i)]  <= bk_cnt[1'(i)] - 3'd1;
                end
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Let combinational outputs settle, then check bank strobe legality on A
    task automatic settle();
        #1;
        check("a_excl", 32'((|ff_push_a) && (|ff_pop_a)), 0);
        check("a_push_oh", 32'($onehot0(ff_push_a)), 1);
        check("a_pop_oh", 32'($onehot0(ff_pop_a)), 1);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_out_a(input string tag, input int vld, input int id, input int data);
        check({tag, "_vld"}, 32'(bus_a.out_valid), vld);
        if (vld != 0) begin
            check({tag, "_id"}, 32'(bus_a.out_id), id);
            check({tag, "_data"}, 32'(bus_a.out_data), data);
        end
    endtask

    int rr_pop [$] = {1, 2, 1, 2, 0};
    int rr_id  [$] = {0, 1, 0, 1};
    int rr_dat [$] = {1, 3, 2, 4};

    int c_id   [$] = {0, 0, 0, 0, 1, 0};
    int c_dat  [$] = {0, 0, 'h30, 0, 'h31, 0};
    int c_rdy  [$] = {0, 0, 1, 0, 1, 0};
    int c_push [$] = {0, 0, 1, 0, 2, 0};
    int c_pop  [$] = {1, 2, 0, 1, 0, 2};
    int c_vld  [$] = {0, 1, 1, 0, 1, 0};
    int c_oid  [$] = {0, 0, 1, 0, 0, 0};
    int c_odat [$] = {0, 1, 3, 0, 2, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        preload         = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_id     = 1'b0;
        bus_a.in_data   = 8'h11;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_id     = 2'd0;
        bus_b.in_data   = 8'h00;
        bus_b.out_ready = 1'b1;
        b_full          = 1'b0;
        b_empty         = 3'b111;
        b_data_out      = 8'h00;

        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            settle();
            check("rst_in_ready", 32'(bus_a.in_ready), 0);
            check("rst_push", 32'(ff_push_a), 0);
            check("rst_pop", 32'(ff_pop_a), 0);
            step();
        end
        rst            = 1'b0;
        bus_a.in_valid = 1'b0;
        settle();
        chk_out_a("post_rst", 0, 0, 0);
        check("post_rst_data", 32'(bus_a.out_data), 0);
        check("post_rst_id", 32'(bus_a.out_id), 0);
        check("post_rst_id_err", 32'(id_err_a), 0);
        check("post_rst_b_vld", 32'(bus_b.out_valid), 0);
        step();

        // Single path: push 0xA5 to FIFO 1, popped next cycle, visible the cycle after
        bus_a.in_valid = 1'b1;
        bus_a.in_id    = 1'b1;
        bus_a.in_data  = 8'hA5;
        settle();
        check("sp_push", 32'(ff_push_a), 2);
        check("sp_ready", 32'(bus_a.in_ready), 1);
        check("sp_pop0", 32'(ff_pop_a), 0);
        step();
        bus_a.in_valid = 1'b0;
        settle();
        check("sp_pop1", 32'(ff_pop_a), 2);
        chk_out_a("sp_t1", 0, 0, 0);
        step();
        settle();
        chk_out_a("sp_t2", 1, 1, 'hA5);
        check("sp_pop2", 32'(ff_pop_a), 0);
        step();
        settle();
        chk_out_a("sp_t3", 0, 0, 0);
        step();

        // Round-robin drain of FIFO0={1,2}, FIFO1={3,4}
        preload = 1'b1;
        settle();
        check("rr_pre_pop", 32'(ff_pop_a), 0);
        step();
        preload = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            check($sformatf("rr_pop%0d", k), 32'(ff_pop_a), rr_pop[k]);
            if (k > 0) chk_out_a($sformatf("rr_out%0d", k), 1, rr_id[k-1], rr_dat[k-1]);
            step();
        end
        settle();
        chk_out_a("rr_end", 0, 0, 0);
        step();

        // Conflict alternation with continuous in_valid
        preload = 1'b1;
        settle();
        step();
        preload = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_id    = 1'(c_id[k]);
            bus_a.in_data  = 8'(c_dat[k]);
            settle();
            check($sformatf("cf_rdy%0d", k), 32'(bus_a.in_ready), c_rdy[k]);
            check($sformatf("cf_push%0d", k), 32'(ff_push_a), c_push[k]);
            check($sformatf("cf_pop%0d", k), 32'(ff_pop_a), c_pop[k]);
            chk_out_a($sformatf("cf_out%0d", k), c_vld[k], c_oid[k], c_odat[k]);
            step();
        end
        bus_a.in_valid = 1'b0;
        settle();
        chk_out_a("dr0", 1, 1, 4);
        step();
        settle();
        chk_out_a("dr1", 1, 0, 'h30);
        step();
        settle();
        chk_out_a("dr2", 1, 1, 'h31);
        step();
        settle();
        chk_out_a("dr3", 0, 0, 0);
        step();

        // Full and output backpressure
        bus_a.out_ready = 1'b0;
        preload         = 1'b1;
        settle();
        step();
        preload        = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_id    = 1'b0;
        bus_a.in_data  = 8'h40;
        settle();
        check("fl1_rdy", 32'(bus_a.in_ready), 0);
        check("fl1_pop", 32'(ff_pop_a), 1);
        step();
        settle();
        chk_out_a("fl2", 1, 0, 1);
        check("fl2_rdy", 32'(bus_a.in_ready), 1);
        check("fl2_push", 32'(ff_push_a), 1);
        step();
        bus_a.in_data = 8'h41;
        for (int k = 3; k < 5; k++) begin
            settle();
            check($sformatf("fl%0d_rdy", k), 32'(bus_a.in_ready), 0);
            check($sformatf("fl%0d_push", k), 32'(ff_push_a), 0);
            check($sformatf("fl%0d_pop", k), 32'(ff_pop_a), 0);
            chk_out_a($sformatf("fl%0d", k), 1, 0, 1);
            step();
        end
        bus_a.out_ready = 1'b1;
        settle();
        check("fl5_pop", 32'(ff_pop_a), 2);
        check("fl5_rdy", 32'(bus_a.in_ready), 0);
        step();
        bus_a.out_ready = 1'b0;
        settle();
        check("fl6_rdy", 32'(bus_a.in_ready), 1);
        check("fl6_push", 32'(ff_push_a), 1);
        chk_out_a("fl6", 1, 1, 3);
        step();
        bus_a.in_valid = 1'b0;

        // Instance B: valid id 2, then out-of-range id 3
        bus_b.in_valid = 1'b1;
        bus_b.in_id    = 2'd2;
        bus_b.in_data  = 8'h66;
        settle();
        check("b_push2", 32'(ff_push_b), 4);
        check("b_rdy2", 32'(bus_b.in_ready), 1);
        step();
        bus_b.in_id   = 2'd3;
        bus_b.in_data = 8'h77;
        settle();
        check("b_bad_rdy", 32'(bus_b.in_ready), 1);
        check("b_bad_push", 32'(ff_push_b), 0);
        check("b_bad_err0", 32'(id_err_b), 0);
        step();
        bus_b.in_valid = 1'b0;
        settle();
        check("b_bad_err1", 32'(id_err_b), 1);
        step();
        settle();
        check("b_bad_err2", 32'(id_err_b), 0);
        step();
        b_full         = 1'b1;
        bus_b.in_valid = 1'b1;
        settle();
        check("b_full_rdy", 32'(bus_b.in_ready), 0);
        step();
        b_full         = 1'b0;
        bus_b.in_valid = 1'b0;
        settle();
        check("b_full_err", 32'(id_err_b), 0);
        step();

        // Instance B: pop from FIFO 1, stall, then reset discards the entry
        b_empty         = 3'b101;
        b_data_out      = 8'h5C;
        bus_b.out_ready = 1'b0;
        settle();
        check("b_pop", 32'(ff_pop_b), 2);
        step();
        settle();
        check("b_out_vld", 32'(bus_b.out_valid), 1);
        check("b_out_data", 32'(bus_b.out_data), 'h5C);
        check("b_out_id", 32'(bus_b.out_id), 1);
        check("b_stall_pop", 32'(ff_pop_b), 0);
        step();
        rst             = 1'b1;
        bus_b.out_ready = 1'b1;
        settle();
        check("b_rst_pop", 32'(ff_pop_b), 0);
        step();
        rst     = 1'b0;
        b_empty = 3'b111;
        settle();
        check("b_rst_vld", 32'(bus_b.out_valid), 0);
        check("b_rst_data", 32'(bus_b.out_data), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/llfifo_scheduler.md
# llfifo_scheduler

Sequencer and arbiter for the shared-memory linked-list FIFO bank. It accepts tagged writes from one upstream valid/ready port and steers them into the addressed FIFO. It drains all non-empty FIFOs round-robin into one registered valid/ready output. It guarantees the bank sees at most one one-hot push or pop per cycle, never pushes when full and never pops an empty FIFO.

## Interface
Parameters:
- WIDTH, 8, data width; equals the bank's WIDTH
- NUM_FIFOS, 2, number of FIFOs in the bank
- ID_WIDTH, $clog2(NUM_FIFOS) (minimum 1), width of the FIFO id tag

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream write request
- in_id  in  ID_WIDTH  destination FIFO index
- in_data  in  WIDTH  write data
- in_ready  out  1  write accepted this cycle when in_valid && in_ready
- out_valid  out  1  output register holds a popped entry
- out_ready  in  1  downstream consumes when out_valid && out_ready
- out_data  out  WIDTH  popped data
- out_id  out  ID_WIDTH  FIFO index the entry came from
- id_err  out  1  one-cycle pulse: accepted write had in_id >= NUM_FIFOS
- ff_push  out  NUM_FIFOS  zero/one-hot push to bank
- ff_pop  out  NUM_FIFOS  zero/one-hot pop to bank
- ff_data_in  out  WIDTH  bank write data, driven directly from in_data
- ff_full  in  1  bank memory full
- ff_empty  in  NUM_FIFOS  per-FIFO empty
- ff_data_out  in  WIDTH  bank read data; combinational for the popped head

## Operation
- push_ok = in_valid && !ff_full && !rst.
- slot_free = !out_valid || out_ready.
- pop_ok = slot_free && (~ff_empty != 0) && !rst.
- Conflict: when push_ok && pop_ok in the same cycle, the winner is chosen by the 1-bit register pri.
  - pri=0: pop wins; pri=1: push wins.
  - pri toggles only on a conflict cycle, and only after the winning op issues.
  - With no conflict, whichever op is ok issues.
- Push grant:
  - in_ready=1, ff_push = onehot(in_id), ff_data_in=in_data.
  - If in_id >= NUM_FIFOS: ff_push=0, in_ready=1 (write dropped), id_err=1 next cycle.
  - An out-of-range id consumes no ff_full capacity. It still participates in arbitration as a push.
- Pop grant:
  - Round-robin over FIFOs with ff_empty[i]=0, searching from rr_ptr+1 modulo NUM_FIFOS, wrapping.
  - ff_pop = onehot(sel).
  - At the clock edge: out_data <= ff_data_out, out_id <= sel, out_valid <= 1, rr_ptr <= sel.
- Output register:
  - Cleared (out_valid <= 0) when consumed without a new pop.
  - Simultaneous consume and pop reloads it in the same edge.
- ff_push and ff_pop are never both non-zero, and are never more than one-hot.
- ff_empty and ff_full are used as presented. A push at cycle t makes that FIFO eligible for pop only once the bank deasserts empty (t+1).

## Timing
- Reset values (asserted on the edge where rst=1; rst overrides all other activity):
  - out_valid=0, out_data=0, out_id=0, id_err=0
  - rr_ptr=NUM_FIFOS-1, so FIFO 0 is searched first
  - pri=0
- In-reset combinational outputs: in_ready=0, ff_push=0, ff_pop=0.
- Reset mid-operation discards the output register contents. The bank shares rst and clears too.
- in_ready, ff_push and ff_pop are combinational from inputs and state, with zero-cycle handshake.
- Pop latency: a pop issued in cycle t gives out_valid=1 with data in cycle t+1.
- Throughput: 1 op/cycle total. Sustained push+pop demand alternates one push then one pop.
- in_ready may depend on in_valid. Upstream must not make in_valid depend on in_ready.
- Full: in_ready=0 while ff_full=1, regardless of pri.
- All empty: ff_pop=0 and no pop is issued. out_valid falls after consumption.
- Output stall (out_valid=1, out_ready=0): no pop is issued, and pushes proceed unobstructed.

## Test plan
- Reset, NUM_FIFOS=2, DEPTH=4: hold rst 2 cycles with in_valid=1. Require in_ready=0, ff_push=ff_pop=0, and out_valid=0 on the cycle after rst drops.
- Single path: push 0xA5 to id 1 with out_ready=1. Require ff_push=2'b10 at t, ff_pop=2'b10 at t+1, out_valid=1/out_data=0xA5/out_id=1 at t+2.
- Round-robin: preload FIFO0={1,2}, FIFO1={3,4}, then hold out_ready=1. Require the out sequence (id,data) = (0,1),(1,3),(0,2),(1,4), then out_valid=0.
- Conflict alternation: keep both FIFOs non-empty with in_valid=1 continuously. Require the issue order pop,push,pop,push, and never both strobes in one cycle.
- Full/backpressure: fill 4 entries, then in_valid=1 with out_ready=0. Require in_ready=0 and out_data stable. Raise out_ready and require one pop, after which in_ready returns once ff_full drops.
- Bad id and reset mid-op: push in_id=3 with NUM_FIFOS=3 and require ff_push=0, in_ready=1, id_err=1 next cycle. Assert rst while out_valid=1 and require out_valid=0 next cycle.
